bus_splitter: RTL
=================

Name: bus_splitter

Overview:
- Inverse of the team's 8-bit bus combiner: takes one 8-bit source bus and routes each word to one of two destination buses.
- Uses valid/ready handshakes on all three buses.
- Each destination has its own small first-word-fall-through (FWFT) FIFO, so a stalled destination does not block traffic to the other until its own FIFO fills.
- Sits between a single producer (e.g. a drawing-request/RGB source) and two independent consumers.

Parameters:
- WIDTH, 8, data bus width in bits.
- DEPTH, 2, entries per destination FIFO; power of two, minimum 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  when low, no new words are accepted; buffered words still drain.
- in_data  input  WIDTH  source word.
- in_sel  input  1  destination select: 0 = port A, 1 = port B.
- in_valid  input  1  source word and in_sel are valid.
- in_ready  output  1  splitter accepts the word this cycle.
- a_data  output  WIDTH  head word of FIFO A.
- a_valid  output  1  FIFO A non-empty.
- a_ready  input  1  consumer A takes the head word.
- b_data  output  WIDTH  head word of FIFO B.
- b_valid  output  1  FIFO B non-empty.
- b_ready  input  1  consumer B takes the head word.
- busy  output  1  either FIFO non-empty.

Behaviour:
- Reset, synchronous and active-high, sampled on a rising clk edge:
  - Both FIFOs: counts, read pointers and write pointers cleared to 0.
  - Storage cleared to 0.
  - in_ready=0 during the reset cycle.
  - a_valid=0, b_valid=0, a_data=0, b_data=0, busy=0.
- Reset mid-operation discards all buffered words; no partial state survives.
- Acceptance:
  - in_ready = enable AND NOT full[in_sel], evaluated combinationally from registered state only.
  - No combinational path exists from a_ready or b_ready to in_ready.
  - Transfer occurs when in_valid AND in_ready at a clk edge; the word is written at the selected FIFO's write pointer.
- Latency: an accepted word appears on x_data with x_valid=1 in the cycle after acceptance if that FIFO was empty. Minimum latency is 1 cycle.
- Output side:
  - x_valid = (count_x != 0).
  - x_data = storage[rd_ptr_x], registered storage with a combinational read mux.
  - Pop occurs when x_valid AND x_ready.
  - x_data and x_valid stay stable while x_valid=1 and x_ready=0.
  - x_data when x_valid=0: don't-care, except 0 after reset.
- Pointers: log2(DEPTH) bits, wrap modulo DEPTH. Count is log2(DEPTH)+1 bits, range 0..DEPTH.
- Simultaneous events:
  - Push and pop on the same FIFO in one cycle (not full): count unchanged, both pointers advance.
  - Full FIFO being popped this cycle still shows in_ready=0 for that destination. The push is accepted next cycle, with no bypass.
  - Empty FIFO: a push and x_ready in the same cycle does not pop, because x_valid is still 0.
  - Push to A and pop from B in the same cycle are independent.
- Head-of-line: if the selected FIFO is full, in_ready=0 even when the other FIFO has space. The source must hold in_data/in_sel/in_valid stable until accepted.
- enable low: in_ready=0. Outputs keep draining normally. enable does not affect stored data.
- busy = a_valid OR b_valid.
- No word is ever dropped or duplicated; order is preserved per destination.

Test Plan:
- Reset, then in_data=0x5A, in_sel=0, in_valid=1 for one cycle, a_ready=1 -> next cycle a_valid=1, a_data=0x5A; the following cycle a_valid=0, busy=0; b_valid stays 0 throughout.
- b_ready=0; push 0x11 then 0x22 to B -> after 2 accepts in_ready=0 for in_sel=1 while in_sel=0 still shows in_ready=1. Raise b_ready -> b_data 0x11 then 0x22 in order, and in_ready for B returns 1 the cycle after the first pop.
- Streaming alternating sel with both readies high, words 0x01..0x08 -> A receives 0x01,0x03,0x05,0x07 and B receives 0x02,0x04,0x06,0x08, one per cycle with no bubbles. This exercises pointer wrap-around at DEPTH=2.
- enable=0 with in_valid=1 and 2 words buffered in A -> in_ready=0 throughout; A drains both words; after re-enabling, the held word is accepted on the first cycle.
- A full with 0xAA,0xBB; assert reset for one cycle mid-drain -> a_valid=0, busy=0, a_data=0 next cycle; 0xBB is never presented after reset.
- Push and pop on the same FIFO in the same cycle with count=1 -> count stays 1 and the new head is the just-written word on the next cycle.

Source files
------------

// File: rtl/bus_splitter.sv
// ============================================================================
// Module   : bus_splitter
// Purpose  : Routes one valid/ready source bus to two destinations, each
//            with its own first-word-fall-through FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_splitter #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic             full_w  [2];
  logic             valid_w [2];
  logic             push_w  [2];
  logic             pop_w   [2];
  logic             ready_w [2];
  logic [WIDTH-1:0] head_w  [2];

  assign ready_w[0] = a_ready;
  assign ready_w[1] = b_ready;

  // Acceptance depends only on registered fill state, never on the consumer readies.
  assign in_ready  = enable & ~reset & ~full_w[in_sel];
  assign push_w[0] = in_valid & in_ready & ~in_sel;
  assign push_w[1] = in_valid & in_ready &  in_sel;

  for (genvar i = 0; i < 2; i++) begin : g_fifo
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;

    assign pop_w[i] = valid_w[i] & ready_w[i];

    always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (push_w[i]) wr_d = wr_q + 1'b1;
      if (pop_w[i])  rd_d = rd_q + 1'b1;
      if (push_w[i] && !pop_w[i])      cnt_d = cnt_q + 1'b1;
      else if (!push_w[i] && pop_w[i]) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        wr_q  <= '0;
        rd_q  <= '0;
        cnt_q <= '0;
        for (int j = 0; j < DEPTH; j++) mem_q[j] <= '0;
      end else begin
        wr_q  <= wr_d;
        rd_q  <= rd_d;
        cnt_q <= cnt_d;
        if (push_w[i]) mem_q[wr_q] <= in_data;
      end
    end

    assign valid_w[i] = (cnt_q != '0);
    assign full_w[i]  = (cnt_q == CNT_FULL);
    assign head_w[i]  = mem_q[rd_q];
  end

  assign a_data  = head_w[0];
  assign a_valid = valid_w[0];
  assign b_data  = head_w[1];
  assign b_valid = valid_w[1];
  assign busy    = valid_w[0] | valid_w[1];

endmodule

`default_nettype wire
